// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and helpers shared by the PS/2 keyboard receiver.
//   FRAME_BITS  - device-to-host frame length (start, 8 data, parity, stop)
//   BREAK_CODE  - key-release prefix byte
//   EXT_CODE    - extended-key prefix byte
//   SEG_BLANK   - all segments off (active-low)
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_BITS = 1'b1
    } rx_state_t;

    // Frame is stored as captured, bit 0 = start ... bit 10 = stop.
    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: PS/2 pin inputs and decoded keyboard outputs.
//   ps2_clk, ps2_data     raw asynchronous PS/2 lines
//   code, code_valid      last good scan code and its update pulse
//   frame_err             pulse on a rejected frame
//   key_cnt               completed key releases
//   seg_lo, seg_hi        active-low {g,f,e,d,c,b,a} for code nibbles
// Modport slave is the receiver; master is the board/bench side.
interface ps2_keyboard_if;

    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  code;
    logic        code_valid;
    logic        frame_err;
    logic [15:0] key_cnt;
    logic [6:0]  seg_lo;
    logic [6:0]  seg_hi;

    modport slave (
        input  ps2_clk, ps2_data,
        output code, code_valid, frame_err, key_cnt, seg_lo, seg_hi
    );

    modport master (
        output ps2_clk, ps2_data,
        input  code, code_valid, frame_err, key_cnt, seg_lo, seg_hi
    );

endinterface

// File: rtl/hex_seg7.sv
// hex_seg7: hex digit to active-low seven-segment decoder.
//   value - 4-bit digit
//   en    - when 0 the digit is blanked
//   seg   - {g,f,e,d,c,b,a}, active-low
module hex_seg7
    import ps2_pkg::*;
(
    input  logic [3:0] value,
    input  logic       en,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (en) begin
            case (value)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                default: seg = 7'h0E;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with hex display.
//   clk     system clock, rising edge
//   resetn  synchronous reset, active-low
//   bus     ps2_keyboard_if.slave (PS/2 pins in, code/pulses/segments out)
// Parameters: SYNC_STAGES (>=2) synchronizer depth, TIMEOUT_CYCLES idle
// cycles before a partial frame is dropped.
// Optional: define PS2_KEYCNT_EN to count key releases (F0-prefixed codes)
// on key_cnt; otherwise key_cnt is tied to 0.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         resetn,
    ps2_keyboard_if.slave bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    rx_state_t              state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [10:0]            shift_q, shift_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   frame_done;
    logic                   frame_good;

    logic [7:0]             code_q;
    logic                   code_valid_q;
    logic                   frame_err_q;
    logic                   shown_q;

    // Synchronizer / falling-edge detect
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    // Deframer: bits shift in from the top so bit 0 ends up as the start bit.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        to_cnt_d   = to_cnt_q;
        frame_done = 1'b0;
        if (fall) begin
            shift_d  = {data_s, shift_q[10:1]};
            to_cnt_d = '0;
            if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                bit_cnt_d  = '0;
                state_d    = RX_IDLE;
                frame_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                state_d   = RX_BITS;
            end
        end else if (state_q == RX_BITS) begin
            // Saturate at the limit; the frame is abandoned, no pulse raised.
            if (to_cnt_q == TO_MAX) begin
                bit_cnt_d = '0;
                state_d   = RX_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    assign frame_good = frame_ok(shift_d);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Shift register is pure data; stale contents are always overwritten.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Frame completion
    always_ff @(posedge clk) begin
        if (!resetn) begin
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            shown_q      <= 1'b0;
        end else begin
            code_valid_q <= frame_done & frame_good;
            frame_err_q  <= frame_done & ~frame_good;
            if (frame_done && frame_good) begin
                code_q  <= shift_d[8:1];
                shown_q <= 1'b1;
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.frame_err  = frame_err_q;

`ifdef PS2_KEYCNT_EN
    logic        break_pending_q;
    logic [15:0] key_cnt_q;
    logic [7:0]  new_code;

    assign new_code = shift_d[8:1];

    // E0 and rejected frames leave break_pending untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            break_pending_q <= 1'b0;
            key_cnt_q       <= 16'h0000;
        end else if (frame_done && frame_good) begin
            if (new_code == BREAK_CODE) begin
                break_pending_q <= 1'b1;
            end else if (new_code != EXT_CODE && break_pending_q) begin
                break_pending_q <= 1'b0;
                key_cnt_q       <= key_cnt_q + 16'd1;
            end
        end
    end

    assign bus.key_cnt = key_cnt_q;
`else
    assign bus.key_cnt = 16'h0000;
`endif

    hex_seg7 u_seg_lo (
        .value (code_q[3:0]),
        .en    (shown_q),
        .seg   (bus.seg_lo)
    );

    hex_seg7 u_seg_hi (
        .value (code_q[7:4]),
        .en    (shown_q),
        .seg   (bus.seg_hi)
    );

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: bench for ps2_keyboard. Drives PS/2 frames bit by bit and
// compares outputs with a byte-level model of the keyboard protocol.
// Define PS2_KEYCNT_EN for both bench and design to cover the key counter.
module tb_ps2_keyboard;

    localparam int SYNC = 3;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ps2_keyboard_if bus ();

    ps2_keyboard #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int last_valid_cyc = -1000;
    int stop_cyc = 0;

    logic [7:0]  m_code;
    bit          m_shown;
    logic [15:0] m_kc;
`ifdef PS2_KEYCNT_EN
    bit          m_brk;
`endif

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 good, 3 bad parity, 4 bad stop, 5 start bit of 1
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
        logic par, st, sp;
        par = ~^b;
        st  = 1'b0;
        sp  = 1'b1;
        if (kind == 3) par = ~par;
        if (kind == 4) sp = 1'b0;
        if (kind == 5) st = 1'b1;
        return {sp, par, b, st};
    endfunction

    task automatic model_reset();
        m_code  = 8'h00;
        m_shown = 1'b0;
        m_kc    = 16'h0000;
`ifdef PS2_KEYCNT_EN
        m_brk   = 1'b0;
`endif
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code  = b;
        m_shown = 1'b1;
`ifdef PS2_KEYCNT_EN
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hE0 && m_brk) begin
            m_brk = 1'b0;
            m_kc  = m_kc + 16'd1;
        end
`endif
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic check_display(input string tag);
        chk({tag, "_code"}, bus.code, m_code);
        chk({tag, "_seg_lo"}, bus.seg_lo, m_shown ? hex_tab[m_code[3:0]] : 7'h7F);
        chk({tag, "_seg_hi"}, bus.seg_hi, m_shown ? hex_tab[m_code[7:4]] : 7'h7F);
        chk({tag, "_key_cnt"}, bus.key_cnt, m_kc);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] b, input int kind);
        int v0, e0, d;
        bit good;
        good = (kind == 0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(make_frame(b, kind), 11);
        repeat (10) @(negedge clk);
        if (good) model_byte(b);
        chk({tag, "_valid_pulses"}, valid_cnt - v0, good ? 1 : 0);
        chk({tag, "_err_pulses"}, err_cnt - e0, good ? 0 : 1);
        check_display(tag);
        if (good) begin
            d = last_valid_cyc - stop_cyc;
            chk({tag, "_latency"}, (d >= 0 && d <= SYNC + 2) ? 1 : 0, 1);
        end
    endtask

    initial begin
        int v0, e0, sel, kind;
        logic [7:0] b;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_code_valid", bus.code_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        check_display("rst");
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_pulses", valid_cnt + err_cnt, 0);

        send_and_check("f1c", 8'h1C, 0);
        chk("f1c_seg_lo_C", bus.seg_lo, 7'h46);
        chk("f1c_seg_hi_1", bus.seg_hi, 7'h79);

        send_and_check("f16_badpar", 8'h16, 3);
        chk("f16_code_kept", bus.code, 8'h1C);

        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'h45, 0), 6);
        repeat (TO + 20) @(negedge clk);
        chk("timeout_no_err", err_cnt - e0, 0);
        chk("timeout_no_valid", valid_cnt - v0, 0);
        send_and_check("f45", 8'h45, 0);
        chk("f45_code", bus.code, 8'h45);

        send_and_check("kc_1c", 8'h1C, 0);
        send_and_check("kc_f0", 8'hF0, 0);
        send_and_check("kc_1c_rel", 8'h1C, 0);
`ifdef PS2_KEYCNT_EN
        chk("kc_one", bus.key_cnt, 16'd1);
`endif
        send_and_check("kc_e0", 8'hE0, 0);
        send_and_check("kc_f0b", 8'hF0, 0);
        send_and_check("kc_75", 8'h75, 0);
`ifdef PS2_KEYCNT_EN
        chk("kc_two", bus.key_cnt, 16'd2);
`endif

        send_bits(make_frame(8'h29, 0), 5);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check_display("midrst");
        send_and_check("f29", 8'h29, 0);

        send_and_check("startbit1", 8'h5A, 5);
        send_and_check("badstop", 8'h33, 4);

        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) b = 8'hF0;
            else if (sel == 1) b = 8'hE0;
            else b = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            if (kind < 3) kind = 0;
            send_and_check("rand", b, kind);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
